// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: arbitrates one single-ported unified RAM between the
// IF stage (read-only) and the MEM stage (read/write). Each access runs
// IDLE -> BUSY -> RESP; BUSY waits for ram_ready. MEM normally wins, but IF is
// forced after MAX_MEM_STREAK consecutive MEM grants that kept IF waiting.
// Optional feature: define MEM_TIMEOUT_EN to abort a BUSY access after
// TIMEOUT cycles (rdata all ones, sticky err).
module unified_mem_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int MAX_MEM_STREAK = 4,
    parameter int TIMEOUT        = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_done,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    input  logic          ram_ready,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int SW = $clog2(MAX_MEM_STREAK + 1);

    state_t        state_q;
    logic [SW-1:0] streak_q;
    logic          owner_mem_q;
    logic [DW-1:0] if_rdata_q, mem_rdata_q;
    logic          if_done_q, mem_done_q;
    logic          ram_en_q, ram_we_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_wdata_q;
    logic          grant_mem_d;
    logic [SW-1:0] streak_d;
    logic [DW-1:0] rd_capture_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] busy_cnt_q;
    logic          err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // MEM (older instruction) wins unless it has already starved IF for the full streak
    always_comb begin
        grant_mem_d = mem_req & (~if_req | (streak_q != SW'(MAX_MEM_STREAK)));
        streak_d    = '0;
        if (grant_mem_d && if_req && streak_q != SW'(MAX_MEM_STREAK))
            streak_d = streak_q + SW'(1);
        // a completed write returns zero on the load bus
        rd_capture_d = ram_we_q ? '0 : ram_rdata;
    end

    // Access sequencer: every RAM-side and response output is a register of this FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            owner_mem_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
            busy_cnt_q  <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // streak_d is zero whenever if_req is low or IF gets the grant
                    streak_q <= streak_d;
                    if (if_req || mem_req) begin
                        state_q     <= BUSY;
                        ram_en_q    <= 1'b1;
                        owner_mem_q <= grant_mem_d;
`ifdef MEM_TIMEOUT_EN
                        busy_cnt_q  <= CW'(1);
`endif
                        if (grant_mem_d) begin
                            ram_we_q    <= mem_we;
                            ram_addr_q  <= mem_addr;
                            ram_wdata_q <= mem_wdata;
                        end else begin
                            ram_we_q    <= 1'b0;
                            ram_addr_q  <= if_addr;
                            ram_wdata_q <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (ram_ready) begin
                        state_q  <= RESP;
                        ram_en_q <= 1'b0;
                        ram_we_q <= 1'b0;
                        if (owner_mem_q) begin
                            mem_rdata_q <= rd_capture_d;
                            mem_done_q  <= 1'b1;
                        end else begin
                            if_rdata_q  <= rd_capture_d;
                            if_done_q   <= 1'b1;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (busy_cnt_q == CW'(TIMEOUT)) begin
                        state_q  <= RESP;
                        ram_en_q <= 1'b0;
                        ram_we_q <= 1'b0;
                        err_q    <= 1'b1;
                        if (owner_mem_q) begin
                            mem_rdata_q <= '1;
                            mem_done_q  <= 1'b1;
                        end else begin
                            if_rdata_q  <= '1;
                            if_done_q   <= 1'b1;
                        end
                    end else begin
                        busy_cnt_q <= busy_cnt_q + CW'(1);
                    end
`endif
                end
                RESP: begin
                    if_done_q  <= 1'b0;
                    mem_done_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_done   = if_done_q;
    assign mem_done  = mem_done_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign stall_if  = if_req & ~if_done_q;
    assign stall_mem = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: stimulus pushes expected RAM grants
// and responses; a negedge monitor pops and compares when the DUT presents them.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
    logic        if_done, mem_done, stall_if, stall_mem;
    logic        ram_en, ram_we, ram_ready, err;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.AW(32), .DW(32), .MAX_MEM_STREAK(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ready(ram_ready), .err(err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- RAM model ----------------
    logic [31:0] ram_arr [int unsigned];
    int lat  = 0;
    int bcnt = 0;

    assign ram_ready = ram_en && (bcnt == lat);

    // access-cycle counter and write commit
    always @(posedge clk) begin
        if (ram_en && !ram_ready) bcnt <= bcnt + 1;
        else bcnt <= 0;
        if (ram_en && ram_ready && ram_we) ram_arr[ram_addr] = ram_wdata;
    end

    // read data: stored word, or ~addr for locations never written
    always @(negedge clk) begin
        if (ram_en) ram_rdata = ram_arr.exists(ram_addr) ? ram_arr[ram_addr] : ~ram_addr;
        else ram_rdata = 32'h0;
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } grant_t;
    grant_t      grant_q [$];
    logic [31:0] if_q [$];
    logic [31:0] mem_q [$];

    logic        p_en = 0, p_we = 0, p_ifd = 0, p_memd = 0;
    logic [31:0] p_addr = 0, p_wdata = 0;

    // monitor: compare every presented grant/response against the queues
    always @(negedge clk) begin
        if (!rst_n) begin
            p_en = 0; p_ifd = 0; p_memd = 0;
        end else begin
            chk("stall_if", stall_if, if_req & ~if_done);
            chk("stall_mem", stall_mem, mem_req & ~mem_done);
            if (ram_en && !p_en) begin
                if (grant_q.size() == 0) chk("unexpected_grant", 1, 0);
                else begin
                    grant_t g;
                    g = grant_q.pop_front();
                    chk("grant_we", ram_we, g.we);
                    chk("grant_addr", ram_addr, g.addr);
                    if (g.we) chk("grant_wdata", ram_wdata, g.wdata);
                end
            end
            if (ram_en && p_en) begin
                chk("busy_hold_we", ram_we, p_we);
                chk("busy_hold_addr", ram_addr, p_addr);
                chk("busy_hold_wdata", ram_wdata, p_wdata);
            end
            if (if_done) begin
                chk("if_done_pulse", p_ifd, 0);
                if (if_q.size() == 0) chk("stray_if_done", 1, 0);
                else chk("if_rdata", if_rdata, if_q.pop_front());
            end
            if (mem_done) begin
                chk("mem_done_pulse", p_memd, 0);
                if (mem_q.size() == 0) chk("stray_mem_done", 1, 0);
                else chk("mem_rdata", mem_rdata, mem_q.pop_front());
            end
            p_en = ram_en; p_we = ram_we; p_addr = ram_addr; p_wdata = ram_wdata;
            p_ifd = if_done; p_memd = mem_done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_grant(input logic we, input logic [31:0] a, input logic [31:0] d);
        grant_t g;
        g.we = we; g.addr = a; g.wdata = d;
        grant_q.push_back(g);
    endtask

    task automatic do_if(input logic [31:0] a, input logic [31:0] exp, input int l, input int exp_lat);
        int k;
        lat = l;
        push_grant(1'b0, a, 32'h0);
        if_q.push_back(exp);
        if_req = 1; if_addr = a;
        k = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1; k++;
            if (if_done) break;
        end
        chk("if_latency", k, exp_lat);
        @(posedge clk); #1 if_req = 0;
    endtask

    task automatic do_mem(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input int l, input int exp_lat);
        int k;
        lat = l;
        push_grant(we, a, d);
        mem_q.push_back(exp);
        mem_req = 1; mem_we = we; mem_addr = a; mem_wdata = d;
        k = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1; k++;
            if (mem_done) break;
        end
        chk("mem_latency", k, exp_lat);
        @(posedge clk); #1 mem_req = 0;
    endtask

    // both requesters active; IF drops after its first done, MEM after n_mem dones
    task automatic run_both(input int n_mem);
        int md = 0, id = 0;
        logic drop_m = 0, drop_i = 0;
        lat = 0;
        if_req = 1; mem_req = 1;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (drop_m) begin mem_req = 0; drop_m = 0; end
            if (drop_i) begin if_req = 0; drop_i = 0; end
            if (md == n_mem && id == 1 && !mem_req && !if_req) break;
            if (mem_done) begin md++; if (md == n_mem) drop_m = 1; end
            if (if_done) begin id++; drop_i = 1; end
        end
        chk("both_mem_dones", md, n_mem);
        chk("both_if_dones", id, 1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ram_en"}, ram_en, 0);
        chk({tag, "_ram_we"}, ram_we, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ram_wdata"}, ram_wdata, 0);
        chk({tag, "_if_done"}, if_done, 0);
        chk({tag, "_mem_done"}, mem_done, 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_mem_rdata"}, mem_rdata, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        rst_n = 0; if_req = 0; mem_req = 0; mem_we = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0;
        ram_arr[32'h40] = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1 chk_zero_outputs("reset");
        rst_n = 1;
        @(posedge clk); #1;

        // IF only, ready one cycle after ram_en rises: done on the 3rd edge
        do_if(32'h40, 32'hDEADBEEF, 1, 3);

        // MEM write alone, zero wait: minimum 2-edge latency, load bus reads 0
        do_mem(1'b1, 32'h180, 32'hCAFE0001, 32'h0, 0, 2);

        // simultaneous: store @0x100 served first, then IF fetch of the same word
        mem_we = 1; mem_addr = 32'h100; mem_wdata = 32'h12345678; if_addr = 32'h100;
        push_grant(1'b1, 32'h100, 32'h12345678);
        push_grant(1'b0, 32'h100, 32'h0);
        mem_q.push_back(32'h0);
        if_q.push_back(32'h12345678);
        run_both(1);

        // starvation: 4 MEM reads, forced IF, then MEM resumes
        mem_we = 0; mem_addr = 32'h200; if_addr = 32'h80;
        for (int i = 0; i < 4; i++) begin
            push_grant(1'b0, 32'h200, 32'h0);
            mem_q.push_back(32'hFFFFFDFF);
        end
        push_grant(1'b0, 32'h80, 32'h0);
        if_q.push_back(32'hFFFFFF7F);
        push_grant(1'b0, 32'h200, 32'h0);
        mem_q.push_back(32'hFFFFFDFF);
        run_both(5);

        // streak must be back to 0: MEM wins the next tie again
        mem_addr = 32'h180; if_addr = 32'h40;
        push_grant(1'b0, 32'h180, 32'h0);
        push_grant(1'b0, 32'h40, 32'h0);
        mem_q.push_back(32'hCAFE0001);
        if_q.push_back(32'hDEADBEEF);
        run_both(1);

        // variable latency: 7 wait cycles, done on the 9th edge
        do_mem(1'b0, 32'h300, 32'h0, 32'hFFFFFCFF, 7, 9);

`ifdef MEM_TIMEOUT_EN
        // never-ready RAM: abort after 8 BUSY cycles, err sticks
        do_if(32'h500, 32'hFFFFFFFF, 100000, 9);
        chk("err_after_timeout", err, 1);
        do_if(32'h40, 32'hDEADBEEF, 0, 2);
        chk("err_sticky", err, 1);
`else
        chk("err_tied_low", err, 0);
`endif

        // reset in the middle of a BUSY access
        lat = 50;
        push_grant(1'b0, 32'h600, 32'h0);
        if_req = 1; if_addr = 32'h600;
        repeat (3) @(posedge clk);
        #1 chk("pre_reset_busy", ram_en, 1);
        rst_n = 0;
        #1 chk_zero_outputs("midreset");
        if_req = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (6) @(posedge clk);
        #1 chk("post_reset_idle_en", ram_en, 0);

        // a fresh access after reset still works
        do_if(32'h40, 32'hDEADBEEF, 0, 2);

        repeat (2) @(posedge clk);
        #1;
        chk("grant_q_empty", grant_q.size(), 0);
        chk("if_q_empty", if_q.size(), 0);
        chk("mem_q_empty", mem_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
